// File: rtl/throw_trajectory.sv
// Purpose : launch a projectile on throw_flag, integrate a discrete ballistic path per tick, classify the landing.
// Latency : obj_* valid 1 cycle after throw_flag; end_throw 1 cycle after the landing step.
// Backpr. : none; end_throw is held off until throw_flag drops, so a stale flag cannot relaunch.
//
// Ports:
//   clk60MHz        in   system clock
//   rst_n           in   asynchronous active-low reset (aborts any flight silently)
//   throw_flag      in   high from release until end_throw is seen; dropping it mid-flight aborts
//   power[3:0]      in   launch power, stable while throw_flag is high
//   current_player  in   0 = left thrower (+x), 1 = right thrower (-x)
//   obj_x[10:0]     out  projectile x, last on-screen value
//   obj_y[9:0]      out  projectile y, clamped to 0..GROUND_Y
//   obj_active      out  high while in flight
//   end_throw       out  one-cycle landing pulse
//   result[1:0]     out  00 GROUND, 01 WALL, 10 TARGET, 11 OUT; kept until the next landing
module throw_trajectory #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int START_X_L   = 100,
    parameter int START_X_R   = 700,
    parameter int START_Y     = 500,
    parameter int GROUND_Y    = 550,
    parameter int SCREEN_W    = 800,
    parameter int VY_BIAS     = 8,
    parameter int WALL_X_MIN  = 380,
    parameter int WALL_X_MAX  = 420,
    parameter int WALL_Y_TOP  = 300,
    parameter int TGT_L_X0    = 80,
    parameter int TGT_L_X1    = 120,
    parameter int TGT_R_X0    = 680,
    parameter int TGT_R_X1    = 720,
    parameter int TGT_Y0      = 460,
    parameter int TGT_Y1      = 540
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        throw_flag,
    input  logic [3:0]  power,
    input  logic        current_player,
    output logic [10:0] obj_x,
    output logic [9:0]  obj_y,
    output logic        obj_active,
    output logic        end_throw,
    output logic [1:0]  result
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    // Geometry as signed constants matching the position register widths.
    localparam logic signed [11:0] SX_L  = 12'(START_X_L);
    localparam logic signed [11:0] SX_R  = 12'(START_X_R);
    localparam logic signed [11:0] SCR_W = 12'(SCREEN_W);
    localparam logic signed [11:0] WX_LO = 12'(WALL_X_MIN);
    localparam logic signed [11:0] WX_HI = 12'(WALL_X_MAX);
    localparam logic signed [11:0] LX_LO = 12'(TGT_L_X0);
    localparam logic signed [11:0] LX_HI = 12'(TGT_L_X1);
    localparam logic signed [11:0] RX_LO = 12'(TGT_R_X0);
    localparam logic signed [11:0] RX_HI = 12'(TGT_R_X1);
    localparam logic signed [10:0] SY    = 11'(START_Y);
    localparam logic signed [10:0] GY    = 11'(GROUND_Y);
    localparam logic signed [10:0] WY    = 11'(WALL_Y_TOP);
    localparam logic signed [10:0] TY_LO = 11'(TGT_Y0);
    localparam logic signed [10:0] TY_HI = 11'(TGT_Y1);
    localparam logic signed [7:0]  VY_MAX = 8'sd63;

    localparam logic [1:0] RES_GROUND = 2'b00;
    localparam logic [1:0] RES_WALL   = 2'b01;
    localparam logic [1:0] RES_TARGET = 2'b10;
    localparam logic [1:0] RES_OUT    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   tick_cnt;
    logic [3:0]         pwr_q;
    logic               dir_q;
    logic signed [11:0] x_q;
    logic signed [10:0] y_q;
    logic signed [7:0]  vy_q;

    logic signed [11:0] x_nxt;
    logic signed [10:0] y_nxt;
    logic signed [7:0]  vy_nxt;
    logic signed [7:0]  vy_launch;
    logic [9:0]         y_clamp;
    logic               step;
    logic               hit_tgt, hit_wall, hit_gnd, hit_out, hit;
    logic [1:0]         res_d;

    // One physics step on the last cycle of each tick period.
    assign step = (state_q == FLIGHT) && throw_flag && (tick_cnt == TICK_LAST);

    assign vy_launch = -($signed({4'd0, power}) + 8'(VY_BIAS));

    assign x_nxt  = dir_q ? (x_q - $signed({8'd0, pwr_q})) : (x_q + $signed({8'd0, pwr_q}));
    assign y_nxt  = y_q + $signed({{3{vy_q[7]}}, vy_q});
    assign vy_nxt = (vy_q >= VY_MAX) ? VY_MAX : (vy_q + 8'sd1);

    // Above the top of the screen is still a live flight; the sprite just sits on row 0.
    always_comb begin
        y_clamp = y_nxt[9:0];
        if (y_nxt < 11'sd0) begin
            y_clamp = 10'd0;
        end else if (y_nxt >= GY) begin
            y_clamp = GY[9:0];
        end
    end

    // Collision on the post-step position; the target is always the opponent's box.
    always_comb begin
        hit_tgt = 1'b0;
        if (y_nxt >= TY_LO && y_nxt <= TY_HI) begin
            if (dir_q) begin
                hit_tgt = (x_nxt >= LX_LO) && (x_nxt <= LX_HI);
            end else begin
                hit_tgt = (x_nxt >= RX_LO) && (x_nxt <= RX_HI);
            end
        end
        hit_wall = (x_nxt >= WX_LO) && (x_nxt <= WX_HI) && (y_nxt >= WY);
        hit_gnd  = (y_nxt >= GY);
        hit_out  = (x_nxt < 12'sd0) || (x_nxt >= SCR_W);
        hit      = hit_tgt || hit_wall || hit_gnd || hit_out;

        res_d = RES_OUT;
        if (hit_tgt) begin
            res_d = RES_TARGET;
        end else if (hit_wall) begin
            res_d = RES_WALL;
        end else if (hit_gnd) begin
            res_d = RES_GROUND;
        end
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (throw_flag) begin
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (!throw_flag) begin
                    state_d = IDLE;
                end else if (step && hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Wait for the power FSM to release the flag before re-arming.
                if (!throw_flag) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            pwr_q      <= 4'd0;
            dir_q      <= 1'b0;
            x_q        <= 12'sd0;
            y_q        <= 11'sd0;
            vy_q       <= 8'sd0;
            obj_x      <= 11'd0;
            obj_y      <= 10'd0;
            obj_active <= 1'b0;
            end_throw  <= 1'b0;
            result     <= RES_GROUND;
        end else begin
            end_throw <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (throw_flag) begin
                        pwr_q      <= power;
                        dir_q      <= current_player;
                        x_q        <= current_player ? SX_R : SX_L;
                        y_q        <= SY;
                        vy_q       <= vy_launch;
                        obj_x      <= current_player ? SX_R[10:0] : SX_L[10:0];
                        obj_y      <= SY[9:0];
                        obj_active <= 1'b1;
                        tick_cnt   <= '0;
                    end
                end
                FLIGHT: begin
                    if (!throw_flag) begin
                        obj_active <= 1'b0;
                    end else if (step) begin
                        tick_cnt <= '0;
                        x_q      <= x_nxt;
                        y_q      <= y_nxt;
                        vy_q     <= vy_nxt;
                        // Off-screen x never reaches the sprite; it keeps the last drawable column.
                        if (!hit_out) begin
                            obj_x <= x_nxt[10:0];
                        end
                        obj_y <= y_clamp;
                        if (hit) begin
                            result     <= res_d;
                            end_throw  <= 1'b1;
                            obj_active <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_throw_trajectory.sv
module tb_throw_trajectory;

    logic        clk60MHz = 1'b0;
    logic        rst_n;
    logic        throw_flag;
    logic [3:0]  power;
    logic        current_player;

    logic [10:0] d_x,   w_x,   p_x;
    logic [9:0]  d_y,   w_y,   p_y;
    logic        d_act, w_act, p_act;
    logic        d_end, w_end, p_end;
    logic [1:0]  d_res, w_res, p_res;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk60MHz = ~clk60MHz;

    // Default geometry with a short tick.
    throw_trajectory #(.TICK_CYCLES(4)) u_def (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .throw_flag(throw_flag), .power(power),
        .current_player(current_player), .obj_x(d_x), .obj_y(d_y), .obj_active(d_act),
        .end_throw(d_end), .result(d_res));

    // Taller wall: the right-hand high arc clips it.
    throw_trajectory #(.TICK_CYCLES(4), .WALL_Y_TOP(200)) u_wall (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .throw_flag(throw_flag), .power(power),
        .current_player(current_player), .obj_x(w_x), .obj_y(w_y), .obj_active(w_act),
        .end_throw(w_end), .result(w_res));

    // Left target box moved onto the wall so both fire on the same step.
    throw_trajectory #(.TICK_CYCLES(4), .WALL_Y_TOP(200), .TGT_L_X0(380), .TGT_L_X1(420),
                       .TGT_Y0(200), .TGT_Y1(540)) u_pri (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .throw_flag(throw_flag), .power(power),
        .current_player(current_player), .obj_x(p_x), .obj_y(p_y), .obj_active(p_act),
        .end_throw(p_end), .result(p_res));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       player;
        logic [3:0] pwr;
        int         steps;
        int         res;
        int         ox;
        int         oy;
    } vec_t;

    vec_t vecs[6];
    localparam int MAX_CYC = 1 + 4 * 60;

    initial begin
        int k;
        int y1;
        int pulses;
        int last_res;
        logic got;

        // x = start +/- p*n, y = 500 - (p+8)*n + n*(n-1)/2, first hit ends the throw
        vecs[0] = '{1'b0, 4'd0,  22, 0, 100, 550};  // vertical arc, ground
        vecs[1] = '{1'b1, 4'd15, 47, 3, 10,  500};  // over the wall, off the left edge
        vecs[2] = '{1'b0, 4'd15, 47, 3, 790, 500};  // mirror: off the right edge
        vecs[3] = '{1'b1, 4'd0,  22, 0, 700, 550};  // vertical arc from the right
        vecs[4] = '{1'b0, 4'd14, 44, 2, 716, 478};  // lands in the right box
        vecs[5] = '{1'b0, 4'd13, 46, 0, 698, 550};  // passes through box x-span, too low

        rst_n = 1'b0;
        throw_flag = 1'b0;
        power = 4'd0;
        current_player = 1'b0;
        repeat (3) @(posedge clk60MHz);
        #1;
        check("reset obj_x", int'(d_x), 0);
        check("reset obj_y", int'(d_y), 0);
        check("reset obj_active", int'(d_act), 0);
        check("reset end_throw", int'(d_end), 0);
        check("reset result", int'(d_res), 0);
        @(negedge clk60MHz);
        rst_n = 1'b1;
        @(negedge clk60MHz);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk60MHz);
            current_player = vecs[i].player;
            power = vecs[i].pwr;
            throw_flag = 1'b1;
            @(posedge clk60MHz);
            #1;
            check($sformatf("v%0d launch active", i), int'(d_act), 1);
            check($sformatf("v%0d launch x", i), int'(d_x), vecs[i].player ? 700 : 100);
            check($sformatf("v%0d launch y", i), int'(d_y), 500);
            k = 1;
            y1 = -1;
            got = 1'b0;
            while (!got && k < MAX_CYC) begin
                @(posedge clk60MHz);
                #1;
                k++;
                if (k == 5) y1 = int'(d_y);
                if (d_end) got = 1'b1;
            end
            check($sformatf("v%0d step1 y", i), y1, 492 - int'(vecs[i].pwr));
            check($sformatf("v%0d end cycle", i), k, 1 + 4 * vecs[i].steps);
            check($sformatf("v%0d result", i), int'(d_res), vecs[i].res);
            check($sformatf("v%0d obj_x", i), int'(d_x), vecs[i].ox);
            check($sformatf("v%0d obj_y", i), int'(d_y), vecs[i].oy);
            check($sformatf("v%0d active at end", i), int'(d_act), 0);
            // Flag still held: the pulse must not repeat and nothing relaunches.
            pulses = 0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk60MHz);
                #1;
                if (d_end || d_act) pulses++;
            end
            check($sformatf("v%0d held flag quiet", i), pulses, 0);
            check($sformatf("v%0d frozen x", i), int'(d_x), vecs[i].ox);
            @(negedge clk60MHz);
            throw_flag = 1'b0;
            @(negedge clk60MHz);
        end
        last_res = int'(d_res);

        // Right thrower at full power: taller wall catches it, and the target wins over the wall.
        @(negedge clk60MHz);
        current_player = 1'b1;
        power = 4'd15;
        throw_flag = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < MAX_CYC) begin
            @(posedge clk60MHz);
            #1;
            k++;
            if (w_end) got = 1'b1;
        end
        check("wall end cycle", k, 1 + 4 * 19);
        check("wall result", int'(w_res), 1);
        check("wall obj_x", int'(w_x), 415);
        check("wall obj_y", int'(w_y), 234);
        check("prio end_throw", int'(p_end), 1);
        check("prio result", int'(p_res), 2);
        check("default still flying", int'(d_act), 1);

        // Abort the default instance mid-flight.
        @(negedge clk60MHz);
        throw_flag = 1'b0;
        @(posedge clk60MHz);
        #1;
        check("abort active", int'(d_act), 0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk60MHz);
            #1;
            if (d_end || d_act) pulses++;
        end
        check("abort no pulse", pulses, 0);
        check("abort result kept", int'(d_res), last_res);

        // Reset mid-flight clears everything without waiting for a clock edge.
        @(negedge clk60MHz);
        current_player = 1'b0;
        power = 4'd5;
        throw_flag = 1'b1;
        repeat (10) @(posedge clk60MHz);
        #1;
        check("pre-reset obj_x", int'(d_x), 110);
        check("pre-reset active", int'(d_act), 1);
        @(posedge clk60MHz);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset obj_x", int'(d_x), 0);
        check("async reset obj_y", int'(d_y), 0);
        check("async reset active", int'(d_act), 0);
        check("async reset result", int'(d_res), 0);
        throw_flag = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk60MHz);
            #1;
            if (d_end) pulses++;
            if (c == 3) rst_n = 1'b1;
        end
        check("reset no pulse", pulses, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
